// File: rtl/uart_word_tx.sv
// uart_word_tx
//   Sends a 16-bit word as two back-to-back 8N1 UART bytes, high byte first,
//   then pulses wordComplete for one cycle and holds off for two cycles so the
//   upstream FIFO manager can present its next word before it is latched.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_Word        word to transmit, latched when a frame starts
//   i_Enable      transmit permission, sampled only while idle
//   o_Tx          UART serial line, idle high
//   o_Busy        high from the start bit through the end of the hold-off
//   wordComplete  one-cycle pulse after the second stop bit
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_Word,
  input  logic        i_Enable,
  output logic        o_Tx,
  output logic        o_Busy,
  output logic        wordComplete
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone,
    StHoldoff
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            byte_sel_q, byte_sel_d;
  logic [15:0]     word_q, word_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            wc_q, wc_d;
  logic            cnt_end;
  logic [7:0]      cur_byte_d;

  assign cnt_end = (cnt_q == CntMax);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;

    unique case (state_q)
      StIdle: begin
        if (i_Enable) begin
          word_d     = i_Word;
          byte_sel_d = 1'b0;
          cnt_d      = '0;
          bit_idx_d  = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (cnt_end) begin
          cnt_d   = '0;
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StData: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStop: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (!byte_sel_q) begin
            // Low byte follows immediately, no idle gap.
            byte_sel_d = 1'b1;
            state_d    = StStart;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StHoldoff;
      end
      StHoldoff: begin
        if (cnt_q == CntOne) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_comb begin
    cur_byte_d = byte_sel_d ? word_d[7:0] : word_d[15:8];
    tx_d       = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
    wc_d   = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_sel_q <= 1'b0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wc_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_sel_q <= byte_sel_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wc_q       <= wc_d;
    end
  end

  assign o_Tx         = tx_q;
  assign o_Busy       = busy_q;
  assign wordComplete = wc_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Testbench for uart_word_tx with CLKS_PER_BIT=4. Expected bytes and words are
// queued when a frame is launched; a line decoder and a wordComplete monitor
// pop and compare independently of the stimulus.
module tb_uart_word_tx;

  localparam int unsigned Cpb = 4;

  logic        clk;
  logic        rst;
  logic [15:0] i_Word;
  logic        i_Enable;
  logic        o_Tx;
  logic        o_Busy;
  logic        wordComplete;

  uart_word_tx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_Word      (i_Word),
    .i_Enable    (i_Enable),
    .o_Tx        (o_Tx),
    .o_Busy      (o_Busy),
    .wordComplete(wordComplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          fails    = 0;
  int          wc_count = 0;
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_wc[$];
  logic [15:0] rx_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Launch one frame: enable for a single cycle. Returns at the negedge of
  // the first start-bit cycle.
  task automatic pulse(input logic [15:0] word, input bit expect_it);
    @(negedge clk);
    i_Word   = word;
    i_Enable = 1'b1;
    if (expect_it) begin
      exp_bytes.push_back(word[15:8]);
      exp_bytes.push_back(word[7:0]);
      exp_wc.push_back(word);
    end
    @(negedge clk);
    i_Enable = 1'b0;
  endtask

  task automatic wait_wc(input string name);
    int n = 0;
    while (wordComplete !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 300), 1);
  endtask

  // Line decoder: samples mid-bit, discards any byte overlapped by reset.
  initial begin
    logic [7:0] data;
    logic       stop_bit;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && o_Tx === 1'b0) begin
        aborted = 1'b0;
        data    = '0;
        repeat (Cpb / 2) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          repeat (Cpb) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          data[b] = o_Tx;
        end
        repeat (Cpb) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        stop_bit = o_Tx;
        if (!aborted) begin
          check("stop bit", stop_bit, 1);
          if (exp_bytes.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected byte: got %0h, expected none", data);
          end else begin
            check("rx byte", data, exp_bytes.pop_front());
          end
          rx_word = {rx_word[7:0], data};
        end
      end
    end
  end

  // wordComplete monitor: the last two decoded bytes must form the word.
  initial begin
    forever begin
      @(negedge clk);
      if (wordComplete === 1'b1) begin
        wc_count++;
        if (exp_wc.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected wordComplete: got %0h, expected none", rx_word);
        end else begin
          check("word at wordComplete", rx_word, exp_wc.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Time order of 0xA55A on the line: start, A5 LSB first, stop, start,
    // 5A LSB first, stop.
    logic [0:19] pat;
    int          wc_before;
    int          gap;
    int          lows;
    int          bad;
    pat = 20'b0101001011_0010110101;

    rst      = 1'b1;
    i_Word   = '0;
    i_Enable = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", o_Tx, 1);
    check("reset busy", o_Busy, 0);
    check("reset wordComplete", wordComplete, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word, cycle-exact line, busy and pulse.
    pulse(16'hA55A, 1'b1);
    for (int c = 1; c <= 84; c++) begin
      check($sformatf("tx cycle %0d", c), o_Tx, (c <= 80) ? pat[(c - 1) / Cpb] : 1'b1);
      check($sformatf("busy cycle %0d", c), o_Busy, (c <= 83));
      check($sformatf("wc cycle %0d", c), wordComplete, (c == 81));
      if (c < 84) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Back-to-back words with enable held high.
    wc_before = wc_count;
    @(negedge clk);
    i_Word   = 16'h0102;
    i_Enable = 1'b1;
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h02);
    exp_wc.push_back(16'h0102);
    exp_bytes.push_back(8'h03);
    exp_bytes.push_back(8'h04);
    exp_wc.push_back(16'h0304);
    @(negedge clk);
    wait_wc("b2b first wordComplete");
    gap = 0;
    while (o_Tx === 1'b1 && gap < 20) begin
      gap++;
      @(negedge clk);
      if (gap == 1) i_Word = 16'h0304;
    end
    check("b2b idle gap", gap, 4);
    wait_wc("b2b second wordComplete");
    i_Enable = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b pulse count", wc_count - wc_before, 2);

    // Input toggling mid-frame is ignored.
    wc_before = wc_count;
    pulse(16'h3C96, 1'b1);
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      i_Word = ~i_Word;
    end
    check("toggle pulse count", wc_count - wc_before, 1);
    check("toggle idle busy", o_Busy, 0);

    // Sync word: only the two start bits are low.
    wc_before = wc_count;
    lows = 0;
    pulse(16'hFFFF, 1'b1);
    for (int i = 0; i < 90; i++) begin
      if (o_Tx === 1'b0) lows++;
      @(negedge clk);
    end
    check("sync low cycles", lows, 2 * Cpb);
    check("sync pulse count", wc_count - wc_before, 1);

    // Reset during bit 3 of the high byte (0x81: bit 3 is 0).
    wc_before = wc_count;
    pulse(16'h8142, 1'b0);
    repeat (16) @(negedge clk);
    check("pre-reset tx bit3", o_Tx, 0);
    rst = 1'b1;
    #1;
    check("mid-reset tx", o_Tx, 1);
    check("mid-reset busy", o_Busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (45) @(negedge clk);
    check("no wc after reset", wc_count - wc_before, 0);
    check("after reset tx idle", o_Tx, 1);
    pulse(16'h8142, 1'b1);
    wait_wc("post-reset wordComplete");
    repeat (6) @(negedge clk);
    check("post-reset pulse count", wc_count - wc_before, 1);

    // Disabled: nothing happens.
    wc_before = wc_count;
    bad = 0;
    i_Word = 16'h1234;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_Tx !== 1'b1 || o_Busy !== 1'b0 || wordComplete !== 1'b0) bad++;
    end
    check("disabled bad cycles", bad, 0);
    check("disabled pulse count", wc_count - wc_before, 0);

    repeat (10) @(negedge clk);
    check("bytes drained", exp_bytes.size(), 0);
    check("words drained", exp_wc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter that sits directly downstream of the accelerometer FIFO manager. It takes the 16-bit word the manager presents (X, Y, Z sample or the 0xFFFF sync word) and sends it as two 8N1 UART bytes, high byte first. It then pulses `wordComplete` for one cycle so the manager advances to the next axis and pops its FIFO. A fixed hold-off after each word lets the manager's registered data output settle before the next word is latched.

## Interface
- `CLKS_PER_BIT`, default 868 — clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `i_Word`  in  16  word to transmit; connects to the manager's `DataOut`.
- `i_Enable`  in  1  transmit permission; while high, words are sent back-to-back.
- `o_Tx`  out  1  UART serial line; idle level is high.
- `o_Busy`  out  1  high from the start bit through the end of HOLDOFF.
- `wordComplete`  out  1  one-cycle pulse after the second stop bit; connects to the manager's `wordComplete`.

## Operation
- States: IDLE, START, DATA, STOP, DONE, HOLDOFF.
- IDLE
  - `o_Tx`=1, `o_Busy`=0.
  - If `i_Enable`=1 at an edge: latch `i_Word` into the shift buffer, set byte_sel=0, go to START.
- START: `o_Tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA
  - Sends the current byte LSB first, each bit for CLKS_PER_BIT cycles.
  - The current byte is `word[15:8]` when byte_sel=0 and `word[7:0]` when byte_sel=1.
  - After 8 bits, go to STOP.
- STOP
  - `o_Tx`=1 for CLKS_PER_BIT cycles.
  - Then, if byte_sel=0: set byte_sel=1 and go to START, with no idle gap between the two bytes.
  - Otherwise go to DONE.
- DONE: `wordComplete`=1 for exactly one cycle, `o_Tx`=1, then go to HOLDOFF.
- HOLDOFF: 2 cycles with `o_Tx`=1 and `o_Busy`=1, then go to IDLE.
- Latched word
  - The latched word is immutable from latch until DONE.
  - Changes on `i_Word` during a frame are ignored.
- `i_Enable` is sampled only in IDLE. Deasserting it mid-frame does not abort the word; the word completes and `wordComplete` still pulses.
- Counters
  - Bit-time counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index is 3 bits.
- Reset values: state=IDLE, `o_Tx`=1, `o_Busy`=0, `wordComplete`=0, counters=0, byte_sel=0.
- Reset asserted mid-frame: `o_Tx` goes high immediately (asynchronously) and no `wordComplete` is issued for the aborted word.

## Timing
- All outputs are registered.
- Edge E samples `i_Enable`=1 in IDLE. `o_Tx` falls and `o_Busy` rises after edge E and stay so through the start bit.
- One word occupies exactly 20×CLKS_PER_BIT cycles of line time:
  - per byte: 1 start bit, 8 data bits, 1 stop bit;
  - 2 bytes per word.
- `wordComplete` is high in cycle 20×CLKS_PER_BIT+1, counted from the first start-bit cycle as cycle 1.
- Minimum idle-high gap between consecutive words with `i_Enable` held high: 4 cycles (DONE 1 + HOLDOFF 2 + IDLE 1).
- Upstream contract: the manager's `DataOut` reflects the next axis at most 2 cycles after the `wordComplete` pulse. The hold-off guarantees the new value is latched.
- `o_Busy` falls on the edge that enters IDLE.

## Test plan
- **Single word.** CLKS_PER_BIT=4, `i_Word`=0xA55A, `i_Enable` pulsed for 1 cycle.
  - `o_Tx` sequence, each bit 4 cycles: 0, 1,0,1,0,0,1,0,1, 1, 0, 0,1,0,1,1,0,1,0, 1.
  - `wordComplete` is high in cycle 81 only.
  - `o_Busy` is high for 83 cycles.
- **Back-to-back words.** `i_Enable` held high; `i_Word` changes 0x0102 → 0x0304 one cycle after `wordComplete`.
  - Second frame carries bytes 0x03, 0x04.
  - The gap between the frames is 4 idle cycles.
- **Mid-frame data change.** `i_Word` toggles every cycle during the frame.
  - The transmitted bytes equal the value latched at start.
  - Exactly one `wordComplete` pulse.
- **Sync word.** `i_Word`=0xFFFF → line is low only during the two start bits; `wordComplete` pulses once.
- **Reset mid-byte.** Assert `rst` during the DATA bit 3 of the high byte.
  - `o_Tx`=1 and `o_Busy`=0 immediately; no `wordComplete`.
  - After release with `i_Enable`=1, a fresh full frame is sent.
- **Disabled.** `i_Enable`=0 for 200 cycles → `o_Tx` stays 1, `o_Busy`=0, no `wordComplete`.
